// File: rtl/dram_fifo_ctrl_pkg.sv
// Shared constants and types for the 32-deep distributed-RAM FIFO.
package dram_fifo_pkg;
   localparam int DRAM_DEPTH = 32;
   localparam int DRAM_AW    = 5;
   localparam int DRAM_CW    = 6;

   typedef logic [DRAM_AW-1:0] dram_addr_t;
   typedef logic [DRAM_CW-1:0] dram_cnt_t;
endpackage

// File: rtl/dram_fifo_ctrl_if.sv
// FIFO push/pop handshake and status bundle; master is the producer/consumer side.
interface dram_fifo_ctrl_if
   import dram_fifo_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             full;
   logic             almost_full;
   logic             rd_en;
   logic [WIDTH-1:0] rd_data;
   logic             empty;
   logic             almost_empty;
   dram_cnt_t        count;
   logic             overflow;
   logic             underflow;

   modport master (
      output wr_en, wr_data, rd_en,
      input  full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/dram_fifo_ctrl_slice.sv
// One data bit of storage: 32x1 dual-port RAM, synchronous write on port A, async read on DPRA.
module dram_fifo_slice
   import dram_fifo_pkg::*;
(
   input  logic       clk,
   input  logic       we,
   input  logic       d,
   input  dram_addr_t waddr,
   input  dram_addr_t raddr,
   output logic       q
);
   // Written so it maps onto a RAM32X1D; the SPO port has no counterpart here.
   logic mem_q [DRAM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= d;
      end
   end

   assign q = mem_q[raddr];
endmodule

// File: rtl/dram_fifo_ctrl.sv
// 32-deep FWFT FIFO controller over per-bit distributed RAM slices.
// Pointers, occupancy, sticky error bits and count-decoded flags; no comb path from enables to flags.
module dram_fifo_ctrl
   import dram_fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int AFULL_TH  = 28,
   parameter int AEMPTY_TH = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   dram_fifo_ctrl_if.slave  fifo
);
   localparam dram_cnt_t DEPTH_C  = dram_cnt_t'(DRAM_DEPTH);
   localparam dram_cnt_t AFULL_C  = dram_cnt_t'(AFULL_TH);
   localparam dram_cnt_t AEMPTY_C = dram_cnt_t'(AEMPTY_TH);

   dram_addr_t       wr_ptr_q, wr_ptr_d;
   dram_addr_t       rd_ptr_q, rd_ptr_d;
   dram_cnt_t        count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             full, empty, wr_acc, rd_acc, ram_we;
   logic [WIDTH-1:0] rd_data;

   assign full   = (count_q == DEPTH_C);
   assign empty  = (count_q == '0);
   assign wr_acc = fifo.wr_en & ~full;
   assign rd_acc = fifo.rd_en & ~empty;
   // A write coinciding with reset must not disturb RAM contents.
   assign ram_we = wr_acc & rst_n;

   always_comb begin
      wr_ptr_d    = wr_acc ? wr_ptr_q + dram_addr_t'(1) : wr_ptr_q;
      rd_ptr_d    = rd_acc ? rd_ptr_q + dram_addr_t'(1) : rd_ptr_q;
      overflow_d  = overflow_q  | (fifo.wr_en & full);
      underflow_d = underflow_q | (fifo.rd_en & empty);
      count_d     = count_q;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + dram_cnt_t'(1);
         2'b01:   count_d = count_q - dram_cnt_t'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      dram_fifo_slice u_slice (
         .clk   (clk),
         .we    (ram_we),
         .d     (fifo.wr_data[b]),
         .waddr (wr_ptr_q),
         .raddr (rd_ptr_q),
         .q     (rd_data[b])
      );
   end

   assign fifo.rd_data      = rd_data;
   assign fifo.full         = full;
   assign fifo.empty        = empty;
   assign fifo.almost_full  = (count_q >= AFULL_C);
   assign fifo.almost_empty = (count_q <= AEMPTY_C);
   assign fifo.count        = count_q;
   assign fifo.overflow     = overflow_q;
   assign fifo.underflow    = underflow_q;
endmodule
